// File: rtl/sparse_mvm_pkg.sv
// ---------------------------------------------------------------------------
// sparse_mvm_pkg
// Shared types and helpers for the sparse matrix-vector multiply engine.
//   state_t      : engine FSM states (load entries, drain MAC pipe, emit y)
//   KIND_VEC/MAT : encoding of the in_kind input
//   default_aw() : accumulator width that cannot overflow for N full-scale
//                  products of two DW-bit operands
// ---------------------------------------------------------------------------
package sparse_mvm_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam logic KIND_VEC = 1'b0;
    localparam logic KIND_MAT = 1'b1;

    function automatic int default_aw(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/sparse_mvm_engine_mac.sv
// ---------------------------------------------------------------------------
// sparse_mac_stage
// Stage 1 of the MAC pipeline: registers the product of a matrix value and
// the matching x element, together with its destination row and a valid tag.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_valid         : a matrix entry is being accepted this cycle
//   i_row           : destination row of the entry
//   i_a, i_x        : matrix value and x[col] operand (DW bits each)
//   o_valid, o_row  : registered tag for stage 2
//   o_prod          : registered 2*DW-bit product (signed when SIGNED != 0)
// ---------------------------------------------------------------------------
module sparse_mac_stage
    import sparse_mvm_pkg::*;
#(
    parameter int DW     = 8,
    parameter int IW     = 2,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [IW-1:0]       i_row,
    input  logic [DW-1:0]       i_a,
    input  logic [DW-1:0]       i_x,
    output logic                o_valid,
    output logic [IW-1:0]       o_row,
    output logic [2*DW-1:0]     o_prod
);

    logic [2*DW-1:0] w_a_ext;
    logic [2*DW-1:0] w_x_ext;
    logic [2*DW-1:0] w_prod;

    // Operands are widened to the full product width first, so the low
    // 2*DW bits of the multiply are the exact signed or unsigned product.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_a_ext = (2*DW)'($signed(i_a));
            assign w_x_ext = (2*DW)'($signed(i_x));
        end else begin : g_unsigned
            assign w_a_ext = (2*DW)'(i_a);
            assign w_x_ext = (2*DW)'(i_x);
        end
    endgenerate

    assign w_prod = w_a_ext * w_x_ext;

    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_row   <= '0;
            o_prod  <= '0;
        end else begin
            o_valid <= i_valid;
            o_row   <= i_row;
            o_prod  <= w_prod;
        end
    end

endmodule

// File: rtl/sparse_mvm_engine.sv
// ---------------------------------------------------------------------------
// sparse_mvm_engine
// Streaming y = A*x for an N x N sparse matrix delivered as (row, col, value)
// nonzeros, with x elements loaded on the same stream.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid / in_ready          : input entry handshake (ready only in LOAD)
//   in_kind                      : KIND_VEC -> x[in_col] = in_data
//                                  KIND_MAT -> A[in_row][in_col] = in_data
//   in_row, in_col, in_data      : entry fields
//   in_last                      : final entry of the job
//   out_valid / out_ready        : result handshake
//   out_idx, out_data            : result index i and y[i] (AW bits)
//   busy                         : high while draining or emitting results
//   nnz_cnt                      : matrix entries accepted this job (saturating)
// ---------------------------------------------------------------------------
module sparse_mvm_engine
    import sparse_mvm_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int AW     = default_aw(DW, N),
    parameter int SIGNED = 0,
    localparam int IW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_kind,
    input  logic [IW-1:0]   in_row,
    input  logic [IW-1:0]   in_col,
    input  logic [DW-1:0]   in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IW-1:0]   out_idx,
    output logic [AW-1:0]   out_data,
    output logic            busy,
    output logic [15:0]     nnz_cnt
);

    state_t          r_state;
    logic [DW-1:0]   r_x   [N];
    logic [AW-1:0]   r_acc [N];
    logic [IW-1:0]   r_out_idx;
    logic [15:0]     r_nnz_cnt;

    logic            w_in_fire;
    logic            w_vec_fire;
    logic            w_mat_fire;
    logic            w_out_fire;
    logic            w_out_done;
    logic            w_mac_valid;
    logic [IW-1:0]   w_mac_row;
    logic [2*DW-1:0] w_mac_prod;
    logic [AW-1:0]   w_prod_ext;

    // in_ready is gated by rst directly so it is low for the whole time rst
    // is asserted and rises in the very first cycle after it is released.
    assign in_ready   = (r_state == ST_LOAD) && !rst;
    assign w_in_fire  = in_valid && in_ready;
    assign w_vec_fire = w_in_fire && (in_kind == KIND_VEC);
    assign w_mat_fire = w_in_fire && (in_kind == KIND_MAT);

    assign out_valid  = (r_state == ST_OUT);
    assign w_out_fire = out_valid && out_ready;
    assign w_out_done = w_out_fire && (r_out_idx == IW'(N - 1));

    assign busy       = (r_state == ST_DRAIN) || (r_state == ST_OUT);
    assign out_idx    = r_out_idx;
    // The accumulators are frozen in OUT, so the selected entry is stable
    // for as long as the downstream stalls.
    assign out_data   = out_valid ? r_acc[r_out_idx] : '0;
    assign nnz_cnt    = r_nnz_cnt;

    sparse_mac_stage #(
        .DW     (DW),
        .IW     (IW),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_mat_fire),
        .i_row   (in_row),
        .i_a     (in_data),
        .i_x     (r_x[in_col]),
        .o_valid (w_mac_valid),
        .o_row   (w_mac_row),
        .o_prod  (w_mac_prod)
    );

    // Bring the product to accumulator width: sign-extend for signed data,
    // zero-extend otherwise; a narrower AW simply keeps the low bits, which
    // is the modulo-2^AW wrap the accumulators use anyway.
    generate
        if (SIGNED != 0) begin : g_ext_signed
            assign w_prod_ext = AW'($signed(w_mac_prod));
        end else begin : g_ext_unsigned
            assign w_prod_ext = AW'(w_mac_prod);
        end
    endgenerate

    // FSM plus the state it owns: x register file, accumulators, result
    // index and nonzero counter. The last entry's product reaches the
    // accumulators during DRAIN, so every y is final once OUT is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_out_idx <= '0;
            r_nnz_cnt <= '0;
            // NOTE: x and acc are small flop arrays that must be zeroed by
            // rst, which is why they are not mapped onto a RAM macro.
            for (int i = 0; i < N; i++) begin
                r_x[i]   <= '0;
                r_acc[i] <= '0;
            end
        end else begin
            if (w_vec_fire) begin
                r_x[in_col] <= in_data;
            end
            if (w_mat_fire && (r_nnz_cnt != 16'hFFFF)) begin
                r_nnz_cnt <= r_nnz_cnt + 16'd1;
            end
            // Same-cycle read-modify-write: consecutive entries to one row
            // each see the previous update without a stall.
            if (w_mac_valid) begin
                r_acc[w_mac_row] <= r_acc[w_mac_row] + w_prod_ext;
            end

            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire && in_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    if (w_out_done) begin
                        r_state   <= ST_LOAD;
                        r_out_idx <= '0;
                        r_nnz_cnt <= '0;
                        for (int i = 0; i < N; i++) begin
                            r_acc[i] <= '0;
                        end
                    end else if (w_out_fire) begin
                        r_out_idx <= r_out_idx + IW'(1);
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
